// File: rtl/sha256_msg_ctrl_if.sv
// sha256_msg_ctrl_if: message-in, digest-out and SHA-256 core handshake bundle.
interface sha256_msg_ctrl_if;
  logic [7:0] InData;
  logic InValid, InLast, InReady;
  logic [7:0] OutData;
  logic OutValid, OutReady;
  logic CoreStart;
  logic [511:0] CoreChunk;
  logic [255:0] CoreDigest;
  logic CoreDigestReady;
  logic Busy, ErrLen, ErrTimeout;
  modport master (
    input InData, InValid, InLast, OutReady, CoreDigest, CoreDigestReady,
    output InReady, OutData, OutValid, CoreStart, CoreChunk, Busy, ErrLen, ErrTimeout
  );
  modport slave (
    output InData, InValid, InLast, OutReady, CoreDigest, CoreDigestReady,
    input InReady, OutData, OutValid, CoreStart, CoreChunk, Busy, ErrLen, ErrTimeout
  );
endinterface

// File: rtl/sha256_msg_ctrl.sv
// sha256_msg_ctrl: buffers a 1..55 byte message, pads it, runs the single-chunk core, streams the digest.
module sha256_msg_ctrl #(
  parameter int MAX_BYTES = 55,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W = 20
) (
  input logic Clk,
  input logic Reset,
  sha256_msg_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, PAD, START, WAIT, SEND} state_t;
  state_t state;
  logic [7:0] msg [56];
  logic [5:0] count;
  logic [TO_W-1:0] to_cnt;
  logic [511:0] chunk, chunk_d;
  logic [255:0] digest;
  logic [4:0] idx;
  logic rdy_q, skip, accept;
  assign bus.InReady = !Reset && (state == IDLE || state == COLLECT || state == DRAIN);
  assign accept = bus.InValid && bus.InReady;
  assign bus.Busy = state != IDLE;
  assign bus.CoreStart = state == START;
  assign bus.OutValid = state == SEND;
  assign bus.OutData = digest[255:248];
  assign bus.CoreChunk = chunk;
  always_comb begin
    chunk_d = '0;
    for (int i = 0; i < 56; i++)
      chunk_d[511-8*i -: 8] = i < int'(count) ? msg[6'(i)] : (i == int'(count) ? 8'h80 : 8'h00);
    chunk_d[63:0] = {55'd0, count, 3'd0};
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      msg <= '{default: '0};
      count <= '0;
      to_cnt <= '0;
      chunk <= '0;
      digest <= '0;
      idx <= '0;
      rdy_q <= 1'b0;
      skip <= 1'b0;
      bus.ErrLen <= 1'b0;
      bus.ErrTimeout <= 1'b0;
    end else begin
      bus.ErrLen <= 1'b0;
      bus.ErrTimeout <= 1'b0;
      rdy_q <= bus.CoreDigestReady;
      case (state)
        // Idle keeps the buffer zeroed so every message pads over a clean slate
        IDLE: begin
          msg <= '{default: '0};
          count <= '0;
          to_cnt <= '0;
          if (accept) begin
            msg[0] <= bus.InData;
            count <= 6'd1;
            state <= bus.InLast ? PAD : COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            to_cnt <= '0;
            if (count == 6'(MAX_BYTES)) begin
              bus.ErrLen <= 1'b1;
              state <= bus.InLast ? IDLE : DRAIN;
            end else begin
              msg[count] <= bus.InData;
              count <= count + 6'd1;
              if (bus.InLast) state <= PAD;
            end
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            bus.ErrTimeout <= 1'b1;
            state <= IDLE;
          end else to_cnt <= to_cnt + 1'b1;
        end
        DRAIN: if (accept && bus.InLast) state <= IDLE;
        PAD: begin
          chunk <= chunk_d;
          state <= START;
        end
        START: begin
          skip <= 1'b1;
          state <= WAIT;
        end
        // Only a fresh rising edge of the core's done level counts, never a stale high
        WAIT: begin
          skip <= 1'b0;
          if (!skip && !rdy_q && bus.CoreDigestReady) begin
            digest <= bus.CoreDigest;
            idx <= '0;
            state <= SEND;
          end
        end
        SEND: if (bus.OutReady) begin
          digest <= {digest[247:0], 8'h00};
          idx <= idx + 5'd1;
          if (idx == 5'd31) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
